wb_port_arbiter: RTL

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter_pkg.sv | 24 ++
 rtl/wb_pending_fifo.sv | 83 ++++++++
 rtl/wb_port_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared write-back constants and types for the register-file port arbiter.
// Holds the queued-result entry layout and a register one-hot helper.
package wb_port_arbiter_pkg;

    localparam int unsigned FIFO_DEPTH           = 2;
    localparam int unsigned REG_ADDR_W           = 5;
    localparam int unsigned DATA_W               = 32;
    localparam int unsigned NUM_REGS             = 1 << REG_ADDR_W;
    localparam int unsigned STARVE_LIMIT_DEFAULT = 8;

    typedef struct packed {
        logic                  live;
        logic [REG_ADDR_W-1:0] dst;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] mask;
        mask       = '0;
        mask[addr] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/wb_pending_fifo.sv
// Two-entry queue of multi-cycle results awaiting the register-file port.
// Stored entries whose dst matches a younger pipe write lose their live bit.
module wb_pending_fifo
    import wb_port_arbiter_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [REG_ADDR_W-1:0] i_push_dst,
    input  logic [DATA_W-1:0]     i_push_data,
    input  logic                  i_push_live,
    input  logic                  i_pop,
    input  logic                  i_kill,
    input  logic [REG_ADDR_W-1:0] i_kill_dst,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [REG_ADDR_W-1:0] o_head_dst,
    output logic [DATA_W-1:0]     o_head_data,
    output logic                  o_head_live,
    output logic [NUM_REGS-1:0]   o_live_mask
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    wb_entry_t             r_entry   [FIFO_DEPTH];
    wb_entry_t             w_entry_nxt [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_vld;
    logic [FIFO_DEPTH-1:0] w_vld_nxt;
    logic [PtrW-1:0]       r_wr_ptr;
    logic [PtrW-1:0]       r_rd_ptr;

    assign o_full      = &r_vld;
    assign o_empty     = ~|r_vld;
    assign o_head_dst  = r_entry[r_rd_ptr].dst;
    assign o_head_data = r_entry[r_rd_ptr].data;
    assign o_head_live = r_entry[r_rd_ptr].live;

    always_comb begin
        w_entry_nxt = r_entry;
        w_vld_nxt   = r_vld;
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (i_kill && r_vld[i] && (r_entry[i].dst == i_kill_dst)) begin
                w_entry_nxt[i].live = 1'b0;
            end
        end
        if (i_pop) begin
            w_vld_nxt[r_rd_ptr] = 1'b0;
        end
        // Push targets a free slot, so it never collides with the kill above.
        if (i_push) begin
            w_entry_nxt[r_wr_ptr] = '{live: i_push_live, dst: i_push_dst, data: i_push_data};
            w_vld_nxt[r_wr_ptr]   = 1'b1;
        end
    end

    always_comb begin
        o_live_mask = '0;
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (r_vld[i] && r_entry[i].live) begin
                o_live_mask = o_live_mask | reg_onehot(r_entry[i].dst);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_entry  <= '{default: '0};
            r_vld    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_entry <= w_entry_nxt;
            r_vld   <= w_vld_nxt;
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the WB stage and a
// multi-cycle unit; pipe writes always win, MDU results queue and may starve.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_reg_write,
    input  logic [REG_ADDR_W-1:0] pipe_dst,
    input  logic [DATA_W-1:0]     pipe_data,
    input  logic                  mdu_valid,
    input  logic [REG_ADDR_W-1:0] mdu_dst,
    input  logic [DATA_W-1:0]     mdu_data,
    output logic                  mdu_ready,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic [NUM_REGS-1:0]   pending_mask,
    output logic                  stall_req
);

    localparam int unsigned          StarveW   = $clog2(STARVE_LIMIT + 1);
    localparam logic [StarveW-1:0]   StarveMax = StarveW'(STARVE_LIMIT);

    logic                  w_pipe_own;
    logic                  w_push;
    logic                  w_push_store;
    logic                  w_push_live;
    logic                  w_pop;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [REG_ADDR_W-1:0] w_head_dst;
    logic [DATA_W-1:0]     w_head_data;
    logic                  w_head_live;
    logic [StarveW-1:0]    r_starve;
    logic [StarveW-1:0]    w_starve_nxt;
    logic                  r_stall;

    assign w_pipe_own   = pipe_reg_write && (pipe_dst != '0);
    assign mdu_ready    = !w_fifo_full;
    assign w_push       = mdu_valid && mdu_ready;
    // Results for r0 are acknowledged but never occupy a slot.
    assign w_push_store = w_push && (mdu_dst != '0);
    assign w_push_live  = !(w_pipe_own && (pipe_dst == mdu_dst));
    assign w_pop        = !w_fifo_empty && !w_pipe_own;
    assign stall_req    = r_stall;

    wb_pending_fifo u_fifo (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_push      (w_push_store),
        .i_push_dst  (mdu_dst),
        .i_push_data (mdu_data),
        .i_push_live (w_push_live),
        .i_pop       (w_pop),
        .i_kill      (w_pipe_own),
        .i_kill_dst  (pipe_dst),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_head_dst  (w_head_dst),
        .o_head_data (w_head_data),
        .o_head_live (w_head_live),
        .o_live_mask (pending_mask)
    );

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = pipe_dst;
        rf_wdata = pipe_data;
        if (w_pipe_own) begin
            rf_we = 1'b1;
        end else if (w_pop) begin
            rf_we    = w_head_live;
            rf_waddr = w_head_dst;
            rf_wdata = w_head_data;
        end
    end

    always_comb begin
        w_starve_nxt = r_starve;
        if (w_fifo_empty || w_pop) begin
            w_starve_nxt = '0;
        end else if (r_starve != StarveMax) begin
            w_starve_nxt = r_starve + StarveW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            r_starve <= w_starve_nxt;
            r_stall  <= (w_starve_nxt == StarveMax);
        end
    end

endmodule
